// File: rtl/to_serial.sv
// Parallel-to-serial converter: each lane's BW-bit word leaves as CYCS chunks, LS chunk first.
// A one-deep holding register lets back-to-back vectors stream without a gap.
module to_serial #(
  parameter int BW      = 16,
  parameter int CYCS    = 4,
  parameter int VEC_LEN = 27
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              vld_in,
  output logic                              rdy_out,
  input  logic [VEC_LEN-1:0][BW-1:0]        in,
  output logic                              vld_out,
  output logic                              last_out,
  output logic [VEC_LEN-1:0][BW/CYCS-1:0]   out
);

  localparam int CW    = BW / CYCS;
  localparam int CNT_W = $clog2(CYCS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCS - 1);

  logic [VEC_LEN-1:0][BW-1:0] r_sh;
  logic [VEC_LEN-1:0][BW-1:0] r_hold;
  logic                       r_hold_vld;
  logic                       r_busy;
  logic [CNT_W-1:0]           r_cnt;

  logic [VEC_LEN-1:0][BW-1:0] w_sh_nxt;
  logic [VEC_LEN-1:0][BW-1:0] w_hold_nxt;
  logic                       w_hold_vld_nxt;
  logic                       w_busy_nxt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic                       w_acc;
  logic                       w_last;

  // Ready depends only on registered state, so vld_in never reaches rdy_out.
  always_comb begin
    w_acc  = vld_in && !r_hold_vld;
    w_last = r_busy && (r_cnt == CNT_LAST);
  end

  // Next-state: shift mid-word, otherwise reload from hold or input.
  always_comb begin
    w_sh_nxt       = r_sh;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_busy_nxt     = r_busy;
    w_cnt_nxt      = r_cnt;
    if (r_busy && !w_last) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        w_sh_nxt[i] = {{CW{1'b0}}, r_sh[i][BW-1:CW]};
      end
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (w_acc) begin
        w_hold_nxt     = in;
        w_hold_vld_nxt = 1'b1;
      end else begin
        w_hold_nxt     = r_hold;
        w_hold_vld_nxt = r_hold_vld;
      end
    end else begin
      w_cnt_nxt = '0;
      if (r_hold_vld) begin
        w_sh_nxt       = r_hold;
        w_hold_vld_nxt = 1'b0;
        w_busy_nxt     = 1'b1;
      end else if (w_acc) begin
        w_sh_nxt   = in;
        w_busy_nxt = 1'b1;
      end else begin
        w_busy_nxt = 1'b0;
      end
    end
  end

  // State registers; reset discards any partial word and the held vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sh       <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sh       <= w_sh_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Outputs are pure functions of the registers.
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      out[i] = r_sh[i][CW-1:0];
    end
    vld_out  = r_busy;
    last_out = w_last;
    rdy_out  = !r_hold_vld;
  end

endmodule

// File: tb/tb_to_serial.sv
// Self-checking bench for to_serial: directed table, hand-written corner sequences,
// and a randomized run against an abstract queue model with word reassembly.
module tb_to_serial;

  localparam int BW   = 16;
  localparam int CYCS = 4;
  localparam int VL   = 2;
  localparam int CW   = BW / CYCS;

  typedef logic [VL-1:0][BW-1:0] vec_t;
  typedef logic [VL-1:0][CW-1:0] chk_t;
  typedef struct {
    logic vin;
    vec_t din;
    logic e_vld;
    logic e_last;
    logic e_rdy;
    chk_t e_out;
  } rec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic vld_in  = 1'b0;
  logic rdy_out, vld_out, last_out;
  vec_t din = '0;
  chk_t dout;

  int n_cmp  = 0;
  int n_fail = 0;
  rec_t tbl[$];

  // Abstract model: current word + chunk index, queue of waiting vectors, scoreboard.
  logic m_active = 1'b0;
  int   m_k      = 0;
  vec_t m_cur    = '0;
  vec_t m_pend[$];
  vec_t sb[$];

  to_serial #(.BW(BW), .CYCS(CYCS), .VEC_LEN(VL)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .vld_in  (vld_in),
    .rdy_out (rdy_out),
    .in      (din),
    .vld_out (vld_out),
    .last_out(last_out),
    .out     (dout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    vld_in  = 1'b0;
    din     = '0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_active = 1'b0;
    m_k      = 0;
    m_pend.delete();
    sb.delete();
  endtask

  function automatic void add(input logic vin, input logic [15:0] a0, input logic [15:0] a1,
                              input logic ev, input logic el, input logic er,
                              input logic [3:0] c0, input logic [3:0] c1);
    rec_t r;
    r.vin    = vin;
    r.din    = {a1, a0};
    r.e_vld  = ev;
    r.e_last = el;
    r.e_rdy  = er;
    r.e_out  = {c1, c0};
    tbl.push_back(r);
  endfunction

  function automatic logic m_rdy();
    return m_pend.size() == 0;
  endfunction

  function automatic void m_step(input logic v, input vec_t d);
    logic acc;
    acc = v && m_rdy();
    if (acc) sb.push_back(d);
    if (m_active && m_k < CYCS - 1) begin
      m_k++;
      if (acc) m_pend.push_back(d);
    end else if (m_pend.size() > 0) begin
      m_cur    = m_pend.pop_front();
      m_k      = 0;
      m_active = 1'b1;
    end else if (acc) begin
      m_cur    = d;
      m_k      = 0;
      m_active = 1'b1;
    end else begin
      m_active = 1'b0;
      m_k      = 0;
    end
  endfunction

  function automatic chk_t m_chunk();
    chk_t c;
    for (int i = 0; i < VL; i++) c[i] = CW'(m_cur[i] >> (m_k * CW));
    return c;
  endfunction

  initial begin
    vec_t w [0:2];
    vec_t asm_v;
    int   idx;
    int   acc_cnt;
    int   cyc;

    // Reset state
    #3;
    chk("rst_vld", vld_out, 1'b0);
    chk("rst_last", last_out, 1'b0);
    chk("rst_rdy", rdy_out, 1'b1);
    chk("rst_out", dout, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // Single vector
    add(1, 16'hABCD, 16'h1234, 1, 0, 1, 4'hD, 4'h4);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'hC, 4'h3);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'hB, 4'h2);
    add(0, 16'h0, 16'h0, 1, 1, 1, 4'hA, 4'h1);
    add(0, 16'h0, 16'h0, 0, 0, 1, 4'h0, 4'h0);
    // Gap between words
    add(1, 16'h00F0, 16'h5A5A, 1, 0, 1, 4'h0, 4'hA);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'hF, 4'h5);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'h0, 4'hA);
    add(0, 16'h0, 16'h0, 1, 1, 1, 4'h0, 4'h5);
    add(0, 16'h0, 16'h0, 0, 0, 1, 4'h0, 4'h0);
    add(0, 16'h0, 16'h0, 0, 0, 1, 4'h0, 4'h0);
    add(0, 16'h0, 16'h0, 0, 0, 1, 4'h0, 4'h0);
    add(1, 16'h0F00, 16'hC3C3, 1, 0, 1, 4'h0, 4'h3);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'h0, 4'hC);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'hF, 4'h3);
    add(0, 16'h0, 16'h0, 1, 1, 1, 4'h0, 4'hC);
    add(0, 16'h0, 16'h0, 0, 0, 1, 4'h0, 4'h0);
    // Back-to-back with vld_in held high
    add(1, 16'h1111, 16'hEEEE, 1, 0, 1, 4'h1, 4'hE);
    add(1, 16'h2222, 16'hDDDD, 1, 0, 0, 4'h1, 4'hE);
    add(1, 16'h3333, 16'hCCCC, 1, 0, 0, 4'h1, 4'hE);
    add(1, 16'h3333, 16'hCCCC, 1, 1, 0, 4'h1, 4'hE);
    add(1, 16'h3333, 16'hCCCC, 1, 0, 1, 4'h2, 4'hD);
    add(1, 16'h3333, 16'hCCCC, 1, 0, 0, 4'h2, 4'hD);
    add(0, 16'h0, 16'h0, 1, 0, 0, 4'h2, 4'hD);
    add(0, 16'h0, 16'h0, 1, 1, 0, 4'h2, 4'hD);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'h3, 4'hC);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'h3, 4'hC);
    add(0, 16'h0, 16'h0, 1, 0, 1, 4'h3, 4'hC);
    add(0, 16'h0, 16'h0, 1, 1, 1, 4'h3, 4'hC);
    add(0, 16'h0, 16'h0, 0, 0, 1, 4'h0, 4'h0);

    for (int j = 0; j < tbl.size(); j++) begin
      vld_in = tbl[j].vin;
      din    = tbl[j].din;
      tick();
      chk($sformatf("tbl%0d_vld", j), vld_out, tbl[j].e_vld);
      chk($sformatf("tbl%0d_last", j), last_out, tbl[j].e_last);
      chk($sformatf("tbl%0d_rdy", j), rdy_out, tbl[j].e_rdy);
      if (tbl[j].e_vld) chk($sformatf("tbl%0d_out", j), dout, tbl[j].e_out);
    end

    // Backpressure: 0xBEEF offered only while the hold register is full
    do_reset();
    w[0] = '0; w[1] = '0; w[2] = '0;
    for (int c = 0; c < 11; c++) begin
      vld_in = (c <= 3);
      din    = (c == 0) ? {16'h8642, 16'h1357} :
               (c == 1) ? {16'h9753, 16'h2468} :
               (c <= 3) ? {16'hBEEF, 16'hBEEF} : '0;
      tick();
      chk($sformatf("bp%0d_vld", c), vld_out, (c <= 7));
      chk($sformatf("bp%0d_rdy", c), rdy_out, !(c >= 1 && c <= 3));
      if (vld_out && c < 12) begin
        for (int i = 0; i < VL; i++) w[c / 4][i][(c % 4) * CW +: CW] = dout[i];
      end
    end
    chk("bp_word0", w[0], {16'h8642, 16'h1357});
    chk("bp_word1", w[1], {16'h9753, 16'h2468});
    chk("bp_word2", w[2], 32'h0);

    // Reset mid-word with a vector held
    do_reset();
    vld_in = 1'b1;
    din    = {16'h1234, 16'hABCD};
    tick();
    din    = {16'h5555, 16'h6666};
    tick();
    vld_in = 1'b0;
    din    = '0;
    chk("mid_chunk1", dout, {4'h3, 4'hC});
    chk("mid_rdy_full", rdy_out, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", vld_out, 1'b0);
    chk("mid_rst_rdy", rdy_out, 1'b1);
    chk("mid_rst_last", last_out, 1'b0);
    chk("mid_rst_out", dout, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("post_rst%0d_vld", c), vld_out, 1'b0);
    end

    // Randomized run with loopback reassembly
    do_reset();
    acc_cnt = 0;
    cyc     = 0;
    idx     = 0;
    asm_v   = '0;
    while ((acc_cnt < 100 || m_active || sb.size() > 0) && cyc < 3000) begin
      vld_in = (acc_cnt < 100) && ($urandom_range(0, 9) < 6);
      for (int i = 0; i < VL; i++) din[i] = 16'($urandom);
      if (vld_in && m_rdy()) acc_cnt++;
      m_step(vld_in, din);
      tick();
      chk("rnd_vld", vld_out, m_active);
      chk("rnd_last", last_out, m_active && (m_k == CYCS - 1));
      chk("rnd_rdy", rdy_out, m_rdy());
      if (m_active) chk("rnd_out", dout, m_chunk());
      if (vld_out) begin
        if (idx < CYCS) begin
          for (int i = 0; i < VL; i++) asm_v[i][idx * CW +: CW] = dout[i];
        end
        idx++;
        if (last_out) begin
          chk("loop_len", idx, CYCS);
          if (sb.size() > 0) begin
            chk("loopback", asm_v, sb.pop_front());
          end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL loopback_extra: got word %h expected none", asm_v);
          end
          idx = 0;
        end
      end else if (idx != 0) begin
        chk("contig", idx, 0);
        idx = 0;
      end
      cyc++;
    end
    vld_in = 1'b0;
    chk("rnd_accepted", acc_cnt, 100);
    chk("rnd_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
